// File: rtl/async_fifo_write_ctrl.sv
// Write-domain half of an asynchronous FIFO: accepts pushes, strobes the RAM
// write port, maintains binary/Gray write pointers, synchronises the read-side
// Gray pointer and derives pessimistic full / almost-full / level flags.
module async_fifo_write_ctrl #(
  parameter int unsigned FIFO_DATA_WIDTH    = 32,
  parameter int unsigned FIFO_ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned ALMOST_FULL_THRESH = 12
) (
  input  logic                       write_clk,
  input  logic                       write_reset_n,
  input  logic                       write_fifo_push,
  input  logic [FIFO_DATA_WIDTH-1:0] write_data,
  output logic                       write_fifo_full,
  output logic                       write_fifo_almost_full,
  output logic [FIFO_ADDR_WIDTH:0]   write_fifo_level,
  output logic                       write_fifo_overflow,
  output logic                       mem_wr_en,
  output logic [FIFO_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [FIFO_DATA_WIDTH-1:0] mem_wr_data,
  output logic [FIFO_ADDR_WIDTH:0]   write_ptr_gray,
  input  logic [FIFO_ADDR_WIDTH:0]   read_ptr_gray
);

  localparam int unsigned AW = FIFO_ADDR_WIDTH;
  localparam int unsigned PW = FIFO_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < int'(PW); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_match;

  // Push acceptance and same-cycle RAM write strobe.
  always_comb begin
    accept      = write_fifo_push & ~full_q;
    mem_wr_en   = accept;
    mem_wr_addr = wbin_q[AW-1:0];
    mem_wr_data = write_data;
  end

  // Next pointer, flag and level computation against the synchronised read pointer.
  always_comb begin
    rsync         = sync_q[SYNC_STAGES-1];
    rbin          = gray2bin(rsync);
    wbin_d        = wbin_q + PW'(accept);
    wgray_d       = wbin_d ^ (wbin_d >> 1);
    full_match    = {~rsync[AW:AW-1], rsync[AW-2:0]};
    full_d        = (wgray_d == full_match);
    level_d       = wbin_d - rbin;
    almost_full_d = (level_d >= AF_THRESH);
    overflow_d    = overflow_q | (write_fifo_push & full_q);
  end

  // Read-pointer synchroniser: plain flop chain, nothing ahead of the first stage.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= read_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Pointer, flag and level registers.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign write_fifo_full        = full_q;
  assign write_fifo_almost_full = almost_full_q;
  assign write_fifo_level       = level_q;
  assign write_fifo_overflow    = overflow_q;
  assign write_ptr_gray         = wgray_q;

endmodule

// File: tb/tb_async_fifo_write_ctrl.sv
// Bench for async_fifo_write_ctrl: directed scenarios plus an occupancy model
// compared against the DUT on every falling clock edge.
module tb_async_fifo_write_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic [DW-1:0] wdata;
  logic          full, afull, ovf, wr_en;
  logic [AW:0]   level, wgray, rgray;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  async_fifo_write_ctrl #(
    .FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW),
    .SYNC_STAGES(SYNC), .ALMOST_FULL_THRESH(12)
  ) dut (
    .write_clk(clk), .write_reset_n(rst_n),
    .write_fifo_push(push), .write_data(wdata),
    .write_fifo_full(full), .write_fifo_almost_full(afull),
    .write_fifo_level(level), .write_fifo_overflow(ovf),
    .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
    .write_ptr_gray(wgray), .read_ptr_gray(rgray)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [AW:0] g);
    int b = 0;
    logic [AW:0] acc = '0;
    for (int i = AW; i >= 0; i--) begin
      acc[i] = (i == AW) ? g[i] : (acc[i+1] ^ g[i]);
    end
    b = int'(acc);
    return b;
  endfunction

  // Occupancy model: write count vs. the read pointer as it looked SYNC edges ago.
  int          m_wptr;
  int          m_lvl;
  bit          m_full, m_af, m_ovf;
  logic [AW:0] m_hist [SYNC];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wptr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    end else begin
      if (push && !m_full) m_wptr = (m_wptr + 1) % PMOD;
      else if (push) m_ovf = 1;
      m_lvl  = (m_wptr - from_gray(m_hist[SYNC-1]) + PMOD) % PMOD;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= 12);
      for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = rgray;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_full", full, m_full);
      check("m_afull", afull, m_af);
      check("m_level", level, m_lvl);
      check("m_ovf", ovf, m_ovf);
      check("m_gray", wgray, to_gray(m_wptr));
      check("m_wr_en", wr_en, push && !m_full);
      if (push && !m_full) begin
        check("m_addr", wr_addr, m_wptr % DEPTH);
        check("m_data", wr_data, wdata);
      end
      check("inv_level", level <= DEPTH, 1'b1);
      check("inv_en_full", wr_en && full, 1'b0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0;
    rgray = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_full", full, 1'b0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  int edges;

  initial begin
    rst_n = 1'b0; push = 1'b0; wdata = '0; rgray = '0;
    #1;
    check("t1_async_full", full, 1'b0);
    check("t1_async_level", level, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("t1_full", full, 1'b0);
    check("t1_level", level, 0);
    check("t1_gray", wgray, 0);
    check("t1_wr_en", wr_en, 1'b0);

    // Fill sixteen entries with the read pointer parked at zero.
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; wdata = DW'(i);
      #1;
      check("t2_wr_en", wr_en, 1'b1);
      check("t2_addr", wr_addr, i);
      cyc();
      check("t2_level", level, i + 1);
      check("t2_afull", afull, (i + 1) >= 12);
      check("t2_full", full, i == 15);
    end
    push = 1'b0;
    check("t2_gray", wgray, 5'b11000);
    check("t2_level16", level, 16);

    // Pushes while full are dropped and flagged.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; wdata = 32'hDEAD;
      #1;
      check("t3_wr_en", wr_en, 1'b0);
      cyc();
      check("t3_gray", wgray, 5'b11000);
      check("t3_ovf", ovf, 1'b1);
    end
    push = 1'b0;

    // A single pop becomes visible after the synchroniser plus one edge.
    rgray = 5'b00001;
    edges = 0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      if (edges == 0 && full == 1'b0) edges = e;
    end
    check("t4_edges", edges, 3);
    check("t4_level", level, 15);
    push = 1'b1; wdata = 32'h55;
    #1;
    check("t4_addr", wr_addr, 0);
    check("t4_wr_en", wr_en, 1'b1);
    cyc();
    push = 1'b0;
    check("t4_full_again", full, 1'b1);
    check("t4_ovf_sticky", ovf, 1'b1);

    do_reset();
    check("t5_ovf_cleared", ovf, 1'b0);

    // Wrap through the pointer MSB with the reader trailing by two.
    for (int i = 0; i < 40; i++) begin
      rgray = to_gray(i >= 2 ? i - 2 : 0);
      push = 1'b1; wdata = DW'(32'h1000 + i);
      #1;
      check("t5_addr", wr_addr, i % 16);
      check("t5_wr_en", wr_en, 1'b1);
      cyc();
      check("t5_full", full, 1'b0);
    end
    push = 1'b0;
    check("t5_ovf", ovf, 1'b0);
    check("t5_gray", wgray, 5'b01100);

    do_reset();

    // Asynchronous reset between edges in the middle of a burst.
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; wdata = DW'(i);
      cyc();
    end
    check("t6_level4", level, 4);
    #2;
    push = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_full", full, 1'b0);
    check("t6_level", level, 0);
    check("t6_gray", wgray, 0);
    check("t6_ovf", ovf, 1'b0);
    check("t6_addr", wr_addr, 0);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    push = 1'b1; wdata = 32'hBEEF;
    #1;
    check("t6_first_addr", wr_addr, 0);
    check("t6_first_en", wr_en, 1'b1);
    cyc();
    push = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
